// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path:
// segment bit positions, digit indices and BCD patterns.
package stopwatch_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [2:0] DIG_MIL_0 = 3'd0;
   localparam logic [2:0] DIG_MIL_1 = 3'd1;
   localparam logic [2:0] DIG_MIL_2 = 3'd2;
   localparam logic [2:0] DIG_SEC_0 = 3'd3;
   localparam logic [2:0] DIG_SEC_1 = 3'd4;
   localparam logic [2:0] DIG_MIN_0 = 3'd5;
   localparam logic [2:0] DIG_MIN_1 = 3'd6;

   localparam logic [6:0] SEG_DASH = 7'(1 << SEG_G);

   // active-high, bit 6 = g ... bit 0 = a
   localparam logic [6:0] BCD_SEG [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage

// File: rtl/stopwatch_display_bcd2seg.sv
// BCD digit to active-high 7-segment pattern;
// codes 10-15 render as a dash.
module bcd2seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9)
         seg = BCD_SEG[bcd];
   end

endmodule

// File: rtl/stopwatch_display.sv
// 7-digit multiplexed LED scanner: per-frame snapshot,
// leading-zero blanking, status dps, dimming and dead time.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int SCN = 1000,
   parameter int SCL = $clog2(SCN)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     t_mil_0,
   input  logic [3:0]     t_mil_1,
   input  logic [3:0]     t_mil_2,
   input  logic [3:0]     t_sec_0,
   input  logic [3:0]     t_sec_1,
   input  logic [3:0]     t_min_0,
   input  logic [3:0]     t_min_1,
   input  logic           s_run,
   input  logic           s_hld,
   input  logic [SCL-1:0] brt,
   output logic [6:0]     dig_n,
   output logic [6:0]     seg_n,
   output logic           dp_n
);

   localparam logic [SCL-1:0] CNT_MAX = SCL'(SCN - 1);

   logic [SCL-1:0]  cnt_q;
   logic [2:0]      idx_q;
   logic [6:0][3:0] snap_q;
   logic            run_q;
   logic            hld_q;

   logic            last_slot;
   logic            frame_end;
   logic [3:0]      cur;
   logic [6:0]      pat;
   logic            blank;
   logic            dp_d;
   logic            en;
   logic [6:0]      dig_d;

   assign last_slot = (cnt_q == CNT_MAX);
   assign frame_end = last_slot && (idx_q == DIG_MIN_1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= DIG_MIL_0;
      end else if (last_slot) begin
         cnt_q <= '0;
         idx_q <= (idx_q == DIG_MIN_1) ? DIG_MIL_0
                                       : idx_q + 3'd1;
      end else begin
         cnt_q <= cnt_q + SCL'(1);
      end
   end

   // latched once per frame so a scan never mixes two time values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q <= '0;
         run_q  <= 1'b0;
         hld_q  <= 1'b0;
      end else if (frame_end) begin
         snap_q <= {t_min_1, t_min_0, t_sec_1, t_sec_0,
                    t_mil_2, t_mil_1, t_mil_0};
         run_q  <= s_run;
         hld_q  <= s_hld;
      end
   end

   always_comb begin
      cur = '0;
      case (idx_q)
         DIG_MIL_0: cur = snap_q[0];
         DIG_MIL_1: cur = snap_q[1];
         DIG_MIL_2: cur = snap_q[2];
         DIG_SEC_0: cur = snap_q[3];
         DIG_SEC_1: cur = snap_q[4];
         DIG_MIN_0: cur = snap_q[5];
         DIG_MIN_1: cur = snap_q[6];
         default:   cur = '0;
      endcase
   end

   bcd2seg u_bcd2seg (
      .bcd (cur),
      .seg (pat)
   );

   always_comb begin
      dp_d  = 1'b0;
      blank = 1'b0;
      unique case (1'b1)
         (idx_q == DIG_SEC_0): dp_d = 1'b1;
         (idx_q == DIG_MIN_0): begin
            dp_d  = run_q;
            blank = (snap_q[6] == 4'd0) && (snap_q[5] == 4'd0);
         end
         (idx_q == DIG_MIN_1): begin
            dp_d  = hld_q;
            blank = (snap_q[6] == 4'd0);
         end
         default: ;
      endcase
   end

   // cnt==0 is the anti-ghosting dead cycle
   assign en    = (cnt_q != '0) && (cnt_q <= brt);
   assign dig_d = ~(7'(en) << idx_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_n <= 7'h7F;
         seg_n <= 7'h7F;
         dp_n  <= 1'b1;
      end else begin
         dig_n <= dig_d;
         seg_n <= blank ? 7'h7F : ~pat;
         dp_n  <= ~dp_d;
      end
   end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display with SCN=4:
// a cycle model queues expected outputs, a monitor compares.
module tb_stopwatch_display;

   localparam int SCN = 4;
   localparam int SCL = 2;
   localparam int FRM = 7 * SCN;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [3:0]     d [7];
   logic           s_run;
   logic           s_hld;
   logic [SCL-1:0] brt;
   logic [6:0]     dig_n;
   logic [6:0]     seg_n;
   logic           dp_n;

   int checks = 0;
   int errors = 0;

   logic [14:0] q [$];

   int          mt;
   logic [3:0]  ms [7];
   logic        mrun;
   logic        mhld;

   localparam logic [6:0] SEGN [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   stopwatch_display #(.SCN(SCN), .SCL(SCL)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .t_mil_0 (d[0]),
      .t_mil_1 (d[1]),
      .t_mil_2 (d[2]),
      .t_sec_0 (d[3]),
      .t_sec_1 (d[4]),
      .t_min_0 (d[5]),
      .t_min_1 (d[6]),
      .s_run   (s_run),
      .s_hld   (s_hld),
      .brt     (brt),
      .dig_n   (dig_n),
      .seg_n   (seg_n),
      .dp_n    (dp_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [14:0] act,
                      input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got dig=%h seg=%h dp=%b, want dig=%h seg=%h dp=%b",
                  nm, act[14:8], act[7:1], act[0],
                  exp[14:8], exp[7:1], exp[0]);
      end
   endtask

   // reference model: expected output after each clock edge
   always @(posedge clk) begin
      int c, i;
      logic [6:0] s, dg;
      logic p;
      if (!rst_n) begin
         mt = 0;
         for (int k = 0; k < 7; k++) ms[k] = 4'd0;
         mrun = 1'b0;
         mhld = 1'b0;
         q.delete();
      end else begin
         c = mt % SCN;
         i = (mt / SCN) % 7;
         s = (ms[i] <= 4'd9) ? SEGN[ms[i]] : 7'h3F;
         if (i == 6 && ms[6] == 4'd0) s = 7'h7F;
         if (i == 5 && ms[6] == 4'd0 && ms[5] == 4'd0) s = 7'h7F;
         p = !((i == 3) || (i == 5 && mrun) || (i == 6 && mhld));
         dg = 7'h7F;
         if (c >= 1 && c <= int'(brt)) dg[i] = 1'b0;
         q.push_back({dg, s, p});
         if (mt % FRM == FRM - 1) begin
            for (int k = 0; k < 7; k++) ms[k] = d[k];
            mrun = s_run;
            mhld = s_hld;
         end
         mt++;
      end
   end

   always @(negedge clk) begin
      logic [14:0] e;
      if (!rst_n || q.size() == 0) begin
         chk("reset_out", {dig_n, seg_n, dp_n}, {7'h7F, 7'h7F, 1'b1});
      end else begin
         e = q.pop_front();
         chk($sformatf("scan t=%0d", mt - 1),
             {dig_n, seg_n, dp_n}, e);
      end
   end

   task automatic set_time(input logic [3:0] m1, m0, s1, s0,
                           input logic [3:0] ms2, ms1, ms0);
      d[6] = m1; d[5] = m0; d[4] = s1; d[3] = s0;
      d[2] = ms2; d[1] = ms1; d[0] = ms0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      s_run = 1'b0;
      s_hld = 1'b0;
      brt   = 2'd3;
      set_time(0, 0, 0, 0, 0, 0, 0);
      cycles(3);
      rst_n = 1'b1;

      // mid-frame reset at idx=3, cnt=2
      guard = 0;
      while (mt != 14 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (mt != 14) begin
         checks++; errors++;
         $display("FAIL wait_mid: got t=%0d want 14", mt);
      end
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {dig_n, seg_n, dp_n},
             {7'h7F, 7'h7F, 1'b1});
      cycles(3);
      rst_n = 1'b1;
      cycles(8);

      // 0:12.345 running
      set_time(0, 0, 1, 2, 3, 4, 5);
      s_run = 1'b1;
      cycles(3 * FRM);

      // tear: change while idx==2
      guard = 0;
      while (((mt / SCN) % 7) != 2 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      #2;
      set_time(5, 9, 5, 9, 9, 9, 9);
      s_hld = 1'b1;
      s_run = 1'b0;
      cycles(2 * FRM);
      s_run = 1'b1;
      cycles(2 * FRM);

      // brightness sweep
      brt = 2'd0;
      cycles(FRM);
      brt = 2'd1;
      cycles(FRM);
      brt = 2'd2;
      cycles(FRM);
      brt = 2'd3;

      // invalid BCD on digit 4
      set_time(0, 1, 4'hC, 7, 8, 6, 0);
      s_hld = 1'b0;
      s_run = 1'b0;
      cycles(2 * FRM + 4);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
